adder_pipe: RTL and testbench

- Parametrised, pipelined signed adder with valid/ready handshakes on input and output.
- Two modes per beat:
  - ADD: one pairwise sum per accepted beat.
  - ACC: accumulates pairwise sums across a packet and emits one result on the last beat.
- Successor to the single-cycle registered adder; sits in arithmetic datapaths needing flow control, configurable latency and packet accumulation.

---
 rtl/adder_pipe_pkg.sv | 39 +++
 rtl/adder_pipe_stage.sv | 42 ++++
 rtl/adder_pipe.sv | 136 +++++++++++++
 tb/tb_adder_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared mode encoding and signed-arithmetic helpers for adder_pipe.
package adder_pipe_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    localparam int CALC_W = 64;

    typedef struct packed {
        logic signed [CALC_W-1:0] sum;
        logic signed [CALC_W-1:0] wrap;
        logic                     ovf;
    } sat_res_t;

    function automatic logic signed [CALC_W-1:0] smax(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CALC_W-1:0] smin(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Adds exactly, then reports both the clamped and the modulo-2^width result.
    function automatic sat_res_t sat_add(input logic signed [CALC_W-1:0] a,
                                         input logic signed [CALC_W-1:0] b,
                                         input int                       width);
        logic signed [CALC_W-1:0] s;
        sat_res_t                 r;
        s      = a + b;
        r.ovf  = (s > smax(width)) || (s < smin(width));
        r.sum  = (s > smax(width)) ? smax(width) :
                 (s < smin(width)) ? smin(width) : s;
        r.wrap = (s <<< (CALC_W - width)) >>> (CALC_W - width);
        return r;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One enable-gated register stage carrying a result token {valid, sum, last, ovf}.
module adder_pipe_stage #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [W-1:0] sum_i,
    input  logic         last_i,
    input  logic         ovf_i,
    output logic         valid_o,
    output logic [W-1:0] sum_o,
    output logic         last_o,
    output logic         ovf_o
);

    logic         valid_q;
    logic [W-1:0] sum_q;
    logic         last_q;
    logic         ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= sum_i;
            last_q  <= last_i;
            ovf_q   <= ovf_i;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign last_o  = last_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined signed adder with valid/ready flow control and per-packet accumulation.
// Build with ADDER_PIPE_SAT_EN defined to clamp accumulator overflow instead of wrapping.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int  DIW    = 4,
    parameter int  DOW    = DIW + 1,
    parameter int  STAGES = 2,
    parameter type DTYPE  = logic signed
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  DTYPE [DIW-1:0]   ain,
    input  DTYPE [DIW-1:0]   bin,
    input  logic             mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output DTYPE [DOW-1:0]   sum,
    output logic             out_last,
    output logic             ovf
);

`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    if (DOW < DIW + 1) begin : g_bad_dow
        $error("adder_pipe: DOW must be at least DIW+1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("adder_pipe: STAGES must be at least 1");
    end

    logic                  en;
    logic                  accept;
    logic signed [DOW-1:0] p;
    logic signed [DOW-1:0] acc_q, acc_d, acc_sum;
    logic                  sticky_q, sticky_d;
    logic                  acc_ovf;
    sat_res_t              acc_r;

    logic                  v0_q, v0_d;
    logic        [DOW-1:0] s0_q, s0_d;
    logic                  l0_q, l0_d;
    logic                  o0_q, o0_d;

    logic [STAGES-1:0]          v_c;
    logic [STAGES-1:0][DOW-1:0] s_c;
    logic [STAGES-1:0]          l_c;
    logic [STAGES-1:0]          o_c;

    // The whole pipe moves in lockstep; a stalled output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;
    assign accept   = in_valid && in_ready;
    assign p        = DOW'($signed(ain)) + DOW'($signed(bin));

    always_comb begin
        acc_r    = sat_add(CALC_W'(acc_q), CALC_W'(p), DOW);
        acc_sum  = SAT ? DOW'(acc_r.sum) : DOW'(acc_r.wrap);
        acc_ovf  = acc_r.ovf;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        v0_d     = 1'b0;
        s0_d     = p;
        l0_d     = 1'b0;
        o0_d     = 1'b0;
        if (accept) begin
            if (mode_e'(mode) == MODE_ADD) begin
                v0_d = 1'b1;
            end else if (in_last) begin
                v0_d     = 1'b1;
                s0_d     = acc_sum;
                l0_d     = 1'b1;
                o0_d     = sticky_q || acc_ovf;
                acc_d    = '0;
                sticky_d = 1'b0;
            end else begin
                acc_d    = acc_sum;
                sticky_d = sticky_q || acc_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
            v0_q     <= 1'b0;
            s0_q     <= '0;
            l0_q     <= 1'b0;
            o0_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            if (en) begin
                v0_q <= v0_d;
                s0_q <= s0_d;
                l0_q <= l0_d;
                o0_q <= o0_d;
            end
        end
    end

    assign v_c[0] = v0_q;
    assign s_c[0] = s0_q;
    assign l_c[0] = l0_q;
    assign o_c[0] = o0_q;

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        adder_pipe_stage #(.W(DOW)) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .en_i    (en),
            .valid_i (v_c[g-1]),
            .sum_i   (s_c[g-1]),
            .last_i  (l_c[g-1]),
            .ovf_i   (o_c[g-1]),
            .valid_o (v_c[g]),
            .sum_o   (s_c[g]),
            .last_o  (l_c[g]),
            .ovf_o   (o_c[g])
        );
    end

    assign out_valid = v_c[STAGES-1];
    assign sum       = s_c[STAGES-1];
    assign out_last  = l_c[STAGES-1];
    assign ovf       = o_c[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed steps plus random ADD traffic against a queue model.
module tb_adder_pipe;

    localparam int DIW    = 4;
    localparam int DOW    = 5;
    localparam int STAGES = 2;
    localparam int VMAX   = 15;
    localparam int VMIN   = -16;
    localparam int RANGE  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DIW-1:0] ain;
    logic [DIW-1:0] bin;
    logic           mode;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [DOW-1:0] sum;
    logic           out_last;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sum;
        bit last;
        bit ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     acc_m;
    bit     stk_m;
    int     out_cnt = 0;
    integer obs_sum;
    logic   obs_last;
    logic   obs_ovf;
    bit     rand_rdy = 1'b0;

    adder_pipe #(.DIW(DIW), .DOW(DOW), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .mode      (mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic int wrapv(input int v);
        int r;
        r = (v - VMIN) % RANGE;
        if (r < 0) r += RANGE;
        return r + VMIN;
    endfunction

    // Reference behaviour computed with plain integer arithmetic.
    function automatic void model(input int a, input int b, input bit m, input bit l);
        int p;
        int t;
        bit o;
        p = a + b;
        if (!m) begin
            exp_q.push_back('{p, 1'b0, 1'b0});
            return;
        end
        t = acc_m + p;
        o = (t > VMAX) || (t < VMIN);
`ifdef ADDER_PIPE_SAT_EN
        if (t > VMAX) t = VMAX;
        else if (t < VMIN) t = VMIN;
`else
        t = wrapv(t);
`endif
        if (l) begin
            exp_q.push_back('{t, 1'b1, stk_m | o});
            acc_m = 0;
            stk_m = 1'b0;
        end else begin
            acc_m = t;
            stk_m = stk_m | o;
        end
    endfunction

    task automatic chk(input string tag, input integer got, input integer want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d, required %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            out_cnt++;
            obs_sum  = $signed(sum);
            obs_last = out_last;
            obs_ovf  = ovf;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL out_unexpected: got sum=%0d last=%0b ovf=%0b, required no output",
                       obs_sum, obs_last, obs_ovf);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (obs_sum === e.sum && obs_last === e.last && obs_ovf === e.ovf) else begin
                    errors++;
                    $error("FAIL out_token: got sum=%0d last=%0b ovf=%0b, required sum=%0d last=%0b ovf=%0b",
                           obs_sum, obs_last, obs_ovf, e.sum, e.last, e.ovf);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int a, input int b, input bit m, input bit l);
        bit done;
        int n;
        done     = 1'b0;
        n        = 0;
        ain      = DIW'(a);
        bin      = DIW'(b);
        mode     = m;
        in_last  = l;
        in_valid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model(a, b, m, l);
                done = 1'b1;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (exp_q.size() == 0 && out_valid === 1'b0) break;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        acc_m = 0;
        stk_m = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        int h_sum;
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ain       = '0;
        bin       = '0;
        mode      = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        acc_m     = 0;
        stk_m     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        step();

        // ADD latency: visible exactly two cycles after acceptance, for one cycle.
        send(7, 7, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_lat_cycle1", out_valid, 0);
        step();
        @(negedge clk);
        chk("add_lat_cycle2", out_valid, 1);
        chk("add_sum_7_7", $signed(sum), 14);
        chk("add_last", out_last, 0);
        chk("add_ovf", ovf, 0);
        step();
        @(negedge clk);
        chk("add_one_cycle", out_valid, 0);
        step();

        send(-8, -8, 1'b0, 1'b0);
        drain();
        chk("add_sum_neg", obs_sum, -16);

        // Four-beat accumulation overflowing the 5-bit range.
        c0 = out_cnt;
        for (int i = 0; i < 4; i++) send(7, 7, 1'b1, i == 3);
        drain();
        chk("acc4_token_count", out_cnt - c0, 1);
`ifdef ADDER_PIPE_SAT_EN
        chk("acc4_sum", obs_sum, 15);
`else
        chk("acc4_sum", obs_sum, -8);
`endif
        chk("acc4_last", obs_last, 1);
        chk("acc4_ovf", obs_ovf, 1);

        // Output stall: everything held, input blocked.
        send(1, 2, 1'b0, 1'b0);
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
            else step();
        end
        chk("stall_out_seen", seen, 1);
        h_sum = $signed(sum);
        chk("stall_sum_value", h_sum, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("stall_sum_held", $signed(sum), h_sum);
            chk("stall_flags_held", {out_valid, out_last, ovf}, 3'b100);
            chk("stall_in_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        drain();

        c0 = out_cnt;
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++)
            send(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b0, 1'b0);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rand_token_count", out_cnt - c0, 16);

        // Reset mid-packet with an ADD token still in flight.
        send(3, 3, 1'b1, 1'b0);
        send(3, 3, 1'b1, 1'b0);
        c0 = out_cnt;
        send(5, 5, 1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        step();
        send(1, 1, 1'b1, 1'b1);
        drain();
        chk("midrst_token_count", out_cnt - c0, 1);
        chk("midrst_sum", obs_sum, 2);
        chk("midrst_ovf", obs_ovf, 0);

        c0 = out_cnt;
        send(2, 3, 1'b1, 1'b0);
        send(1, 1, 1'b0, 1'b0);
        send(1, 0, 1'b1, 1'b1);
        drain();
        chk("ilv_token_count", out_cnt - c0, 2);
        chk("ilv_sum", obs_sum, 6);
        chk("ilv_last", obs_last, 1);
        chk("ilv_ovf", obs_ovf, 0);

        send(-8, -8, 1'b1, 1'b0);
        send(-8, 0, 1'b1, 1'b1);
        drain();
`ifdef ADDER_PIPE_SAT_EN
        chk("negacc_sum", obs_sum, -16);
`else
        chk("negacc_sum", obs_sum, 8);
`endif
        chk("negacc_ovf", obs_ovf, 1);

        repeat (4) step();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
